mcse_resource_arbiter: RTL and testbench

- Round-robin arbiter that shares one resource port among NUM_REQ requesters, e.g. secure-memory/bus/SHA access used by secure-boot and firmware-authentication engines.
- Replaces the static select mux in the MCSE control unit.
- Requests are granted one owner at a time. The owner keeps the grant for a whole transaction.
- A hold-time watchdog revokes a stuck owner, and the resource must go idle before the grant moves to another requester.

---
 rtl/mcse_resource_arbiter.sv | 127 ++++++++++++
 tb/tb_mcse_resource_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mcse_resource_arbiter.sv
// Round-robin owner arbiter for one shared resource: whole-transaction grants,
// hold-time watchdog, and a drain phase so the resource is idle before handover.
module mcse_arb_lane (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic set_to,
  input  logic err_clr,
  output logic blocked,
  output logic timeout_err
);
  always_ff @(posedge clk) begin
    if (rst) begin
      blocked     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      // a timed-out requester stays ineligible until it drops req
      if (set_to)    blocked <= 1'b1;
      else if (!req) blocked <= 1'b0;
      if (set_to)       timeout_err <= 1'b1;
      else if (err_clr) timeout_err <= 1'b0;
    end
  end
endmodule

module mcse_resource_arbiter #(
  parameter  int NUM_REQ   = 2,
  parameter  int PAYLOAD_W = 64,
  parameter  int MAX_HOLD  = 1024,
  localparam int OW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*PAYLOAD_W-1:0]  req_payload,
  input  logic                          res_busy,
  input  logic                          err_clr,
  output logic [NUM_REQ-1:0]            grant,
  output logic [OW-1:0]                 owner,
  output logic                          owner_valid,
  output logic [PAYLOAD_W-1:0]          res_payload,
  output logic [NUM_REQ-1:0]            timeout_err
);
  localparam int HCW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HCW-1:0] HOLD_LAST = HCW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam logic [OW-1:0]  LAST_IDX  = OW'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, OWN, DRAIN} state_t;
  state_t state;

  logic [OW-1:0]                     ptr, pick, nxt_ptr;
  logic [NUM_REQ-1:0]                elig, pick_oh, blocked, set_to;
  logic                              pick_vld, timeout;
  logic [HCW-1:0]                    hold_cnt;
  logic [NUM_REQ-1:0][PAYLOAD_W-1:0] payload_v;

  assign payload_v = req_payload;
  assign elig      = req & ~blocked;

  // scan downward so the lowest offset from ptr is the final winner
  always_comb begin
    int idx;
    idx      = 0;
    pick     = '0;
    pick_oh  = '0;
    pick_vld = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (elig[idx]) begin
        pick         = OW'(idx);
        pick_oh      = '0;
        pick_oh[idx] = 1'b1;
        pick_vld     = 1'b1;
      end
    end
  end

  assign nxt_ptr = (owner == LAST_IDX) ? '0 : owner + 1'b1;
  assign timeout = (MAX_HOLD != 0) && (state == OWN) && req[owner] && (hold_cnt == HOLD_LAST);

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign set_to[i] = timeout && (owner == OW'(i));
    mcse_arb_lane u_lane (
      .clk         (clk),
      .rst         (rst),
      .req         (req[i]),
      .set_to      (set_to[i]),
      .err_clr     (err_clr),
      .blocked     (blocked[i]),
      .timeout_err (timeout_err[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      grant       <= '0;
      owner       <= '0;
      owner_valid <= 1'b0;
      ptr         <= '0;
      hold_cnt    <= '0;
    end else begin
      case (state)
        IDLE: if (pick_vld) begin
          grant       <= pick_oh;
          owner       <= pick;
          owner_valid <= 1'b1;
          hold_cnt    <= '0;
          state       <= OWN;
        end
        OWN: begin
          if (hold_cnt != '1) hold_cnt <= hold_cnt + 1'b1;
          if (!req[owner] || timeout) begin
            grant       <= '0;
            owner_valid <= 1'b0;
            ptr         <= nxt_ptr;
            state       <= DRAIN;
          end
        end
        DRAIN: if (!res_busy) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign res_payload = owner_valid ? payload_v[owner] : '0;
endmodule

// File: tb/tb_mcse_resource_arbiter.sv
// Directed bench: grant order via a scoreboard queue, timing/flags via direct checks.
module tb_mcse_resource_arbiter;
  localparam int NR = 2, PW = 8, MH = 16;

  logic              clk = 1'b0;
  logic              rst, res_busy, err_clr;
  logic [NR-1:0]     req, grant, timeout_err;
  logic [NR*PW-1:0]  req_payload;
  logic [PW-1:0]     res_payload;
  logic              owner, owner_valid;

  int n_cmp = 0, n_bad = 0;
  logic [NR-1:0] exp_q[$];
  logic [NR-1:0] prev_g = '0;
  logic          inv;

  always #5 clk = ~clk;

  mcse_resource_arbiter #(.NUM_REQ(NR), .PAYLOAD_W(PW), .MAX_HOLD(MH)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_payload (req_payload),
    .res_busy    (res_busy),
    .err_clr     (err_clr),
    .grant       (grant),
    .owner       (owner),
    .owner_valid (owner_valid),
    .res_payload (res_payload),
    .timeout_err (timeout_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(output int cyc);
    cyc = 0;
    do begin
      tick(1);
      cyc++;
    end while (grant == '0 && cyc < 20);
  endtask

  // each new grant pops the next expected owner; invariants every cycle
  always @(negedge clk) begin
    inv = $onehot0(grant) && ((grant != '0) == owner_valid) && (grant[owner] == owner_valid);
    chk("invariant", 64'(inv), 64'h1);
    if (grant !== prev_g) begin
      if (grant != '0)
        chk("grant_seq", 64'(grant), (exp_q.size() > 0) ? 64'(exp_q.pop_front()) : 64'h0);
      prev_g = grant;
    end
  end

  initial begin
    int cyc, own;
    rst = 1'b1; req = '0; res_busy = 1'b0; err_clr = 1'b0;
    req_payload = 16'h3CA5;
    tick(2);
    chk("rst_grant", 64'(grant), 64'h0);
    chk("rst_valid", 64'(owner_valid), 64'h0);
    chk("rst_owner", 64'(owner), 64'h0);
    chk("rst_terr", 64'(timeout_err), 64'h0);
    chk("rst_payload", 64'(res_payload), 64'h0);
    rst = 1'b0;

    // single requester: one-cycle grant latency, payload routing
    req = 2'b01; exp_q.push_back(2'b01);
    tick(1);
    chk("basic_grant", 64'(grant), 64'h1);
    chk("basic_payload", 64'(res_payload), 64'hA5);
    chk("basic_owner", 64'(owner), 64'h0);
    req = 2'b00;
    tick(1);
    chk("rel_grant", 64'(grant), 64'h0);
    chk("rel_payload", 64'(res_payload), 64'h0);
    chk("rel_valid", 64'(owner_valid), 64'h0);
    tick(1);

    // fairness from pointer 0, two idle cycles between grants
    rst = 1'b1; tick(1); rst = 1'b0;
    req = 2'b11;
    for (int n = 0; n < 4; n++) begin
      int o;
      o = n % 2;
      exp_q.push_back(o ? 2'b10 : 2'b01);
      wait_grant(cyc);
      if (n > 0) chk("fair_gap", 64'(cyc), 64'h2);
      chk("fair_owner", 64'(owner), 64'(o));
      chk("fair_payload", 64'(res_payload), o ? 64'h3C : 64'hA5);
      tick(2);
      req[o] = 1'b0;
      tick(1);
      chk("fair_release", 64'(grant), 64'h0);
      req[o] = 1'b1;
    end
    req = 2'b00;
    tick(3);

    // drain: handover waits for res_busy to fall
    req = 2'b01; exp_q.push_back(2'b01);
    tick(1);
    chk("drain_own", 64'(grant), 64'h1);
    req = 2'b10; res_busy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick(1);
      chk("drain_hold", 64'(grant), 64'h0);
    end
    res_busy = 1'b0; exp_q.push_back(2'b10);
    wait_grant(cyc);
    chk("drain_gap", 64'(cyc), 64'h2);
    tick(2);
    req = 2'b00;
    tick(1);
    chk("drain_rel", 64'(grant), 64'h0);
    tick(2);

    // watchdog: requester 0 never releases
    req = 2'b11; exp_q.push_back(2'b01);
    tick(1);
    chk("wd_grant", 64'(grant), 64'h1);
    own = 0;
    while (grant == 2'b01 && own < 100) begin
      own++;
      tick(1);
    end
    chk("wd_hold", 64'(own), 64'(MH));
    chk("wd_terr", 64'(timeout_err), 64'h1);
    chk("wd_drop", 64'(grant), 64'h0);
    exp_q.push_back(2'b10);
    wait_grant(cyc);
    chk("wd_other", 64'(grant), 64'h2);
    chk("wd_gap", 64'(cyc), 64'h2);
    tick(2);
    req = 2'b01;
    tick(1);
    chk("wd_rel1", 64'(grant), 64'h0);
    for (int k = 0; k < 16; k++) begin
      tick(1);
      chk("wd_blocked", 64'(grant), 64'h0);
    end

    err_clr = 1'b1; tick(1); err_clr = 1'b0;
    chk("errclr", 64'(timeout_err), 64'h0);

    // req0 drops, unblocks, then times out again with err_clr in the same cycle
    req = 2'b00; tick(1);
    req = 2'b01; exp_q.push_back(2'b01);
    wait_grant(cyc);
    chk("regrant_gap", 64'(cyc), 64'h1);
    tick(MH - 1);
    err_clr = 1'b1; tick(1); err_clr = 1'b0;
    chk("errclr_set_wins", 64'(timeout_err), 64'h1);
    chk("wd2_drop", 64'(grant), 64'h0);

    // reset while owning; pointer must restart at 0
    req = 2'b00; tick(1);
    req = 2'b01; exp_q.push_back(2'b01);
    wait_grant(cyc);
    chk("rst_pre", 64'(grant), 64'h1);
    tick(2);
    rst = 1'b1;
    tick(1);
    chk("rst_mid_grant", 64'(grant), 64'h0);
    chk("rst_mid_valid", 64'(owner_valid), 64'h0);
    chk("rst_mid_terr", 64'(timeout_err), 64'h0);
    chk("rst_mid_owner", 64'(owner), 64'h0);
    rst = 1'b0;
    req = 2'b11; exp_q.push_back(2'b01);
    wait_grant(cyc);
    chk("rst_ptr", 64'(grant), 64'h1);
    req = 2'b00;
    tick(3);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
